// File: rtl/trip_fare_meter.sv
// Trip state machine and fare accumulator driven by the taxi counter's status code.
// Distance tracks signed movement; fare = BASE_FARE + RATE*distance, clamped at both ends.
module trip_fare_meter #(
    parameter int DIST_W    = 8,
    parameter int FARE_W    = 16,
    parameter int BASE_FARE = 20,
    parameter int RATE      = 5,
    parameter int ERR_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        incr_decr_error,
    input  logic              trip_start,
    input  logic              trip_end,
    output logic [DIST_W-1:0] distance,
    output logic [FARE_W-1:0] fare,
    output logic              busy,
    output logic              trip_done,
    output logic              fault
);
    localparam int ERR_W = $clog2(ERR_LIMIT + 1);
    localparam logic [DIST_W-1:0] DIST_MAX = '1;
    localparam logic [FARE_W-1:0] FARE_MAX = '1;
    localparam logic [FARE_W-1:0] BASE = FARE_W'(BASE_FARE);
    localparam logic [FARE_W-1:0] STEP = FARE_W'(RATE);
    localparam logic [FARE_W:0] STEP_X = (FARE_W+1)'(RATE);
    localparam logic [FARE_W:0] FLOOR_X = {1'b0, BASE} + STEP_X;
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;

    state_t state, state_nxt;
    logic [DIST_W-1:0] dist_nxt;
    logic [FARE_W-1:0] fare_nxt;
    logic [ERR_W-1:0] err_cnt, err_nxt;
    logic [FARE_W:0] fare_up;
    logic is_incr, is_decr, is_err;

    assign is_incr = (incr_decr_error == 3'b100);
    assign is_decr = (incr_decr_error == 3'b010);
    // Every code other than incr, decr and idle counts as a sensor error.
    assign is_err = !is_incr && !is_decr && (incr_decr_error != 3'b000);
    assign fare_up = {1'b0, fare} + STEP_X;

    always_comb begin
        state_nxt = state;
        dist_nxt  = distance;
        fare_nxt  = fare;
        err_nxt   = err_cnt;
        case (state)
            IDLE, FAULT: begin
                if (trip_start) begin
                    state_nxt = RUN;
                    dist_nxt  = '0;
                    fare_nxt  = BASE;
                    err_nxt   = '0;
                end
            end
            RUN: begin
                err_nxt = is_err ? err_cnt + 1'b1 : '0;
                if (is_incr && distance != DIST_MAX) begin
                    dist_nxt = distance + 1'b1;
                    fare_nxt = fare_up[FARE_W] ? FARE_MAX : fare_up[FARE_W-1:0];
                end
                if (is_decr && distance != '0) begin
                    dist_nxt = distance - 1'b1;
                    fare_nxt = ({1'b0, fare} >= FLOOR_X) ? fare - STEP : BASE;
                end
                // A completing error burst outranks a trip close in the same cycle.
                if (is_err && err_cnt == ERR_LAST)
                    state_nxt = FAULT;
                else if (trip_end)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            distance  <= '0;
            fare      <= '0;
            err_cnt   <= '0;
            busy      <= 1'b0;
            trip_done <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            distance  <= dist_nxt;
            fare      <= fare_nxt;
            err_cnt   <= err_nxt;
            busy      <= (state_nxt == RUN);
            trip_done <= (state_nxt == DONE);
            fault     <= (state_nxt == FAULT);
        end
    end
endmodule

// File: tb/tb_trip_fare_meter.sv
// Directed bench for trip_fare_meter with hand-computed fare/distance expectations.
// Default parameters: BASE_FARE 20, RATE 5, ERR_LIMIT 3, 8-bit distance.
module tb_trip_fare_meter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  incr_decr_error = 3'b000;
    logic        trip_start = 1'b0;
    logic        trip_end = 1'b0;
    logic [7:0]  distance;
    logic [15:0] fare;
    logic        busy, trip_done, fault;

    int total = 0;
    int fails = 0;

    localparam logic [2:0] C_IDLE = 3'b000;
    localparam logic [2:0] C_INC  = 3'b100;
    localparam logic [2:0] C_DEC  = 3'b010;
    localparam logic [2:0] C_ERR  = 3'b001;

    trip_fare_meter dut (
        .clk(clk),
        .rst(rst),
        .incr_decr_error(incr_decr_error),
        .trip_start(trip_start),
        .trip_end(trip_end),
        .distance(distance),
        .fare(fare),
        .busy(busy),
        .trip_done(trip_done),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] c, input logic s, input logic e);
        incr_decr_error = c;
        trip_start = s;
        trip_end = e;
        @(posedge clk);
        #1;
        incr_decr_error = C_IDLE;
        trip_start = 1'b0;
        trip_end = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int d, input int f,
                           input logic b, input logic td, input logic ft);
        chk({tag, ".distance"}, 32'(distance), 32'(d));
        chk({tag, ".fare"}, 32'(fare), 32'(f));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".trip_done"}, 32'(trip_done), 32'(td));
        chk({tag, ".fault"}, 32'(fault), 32'(ft));
    endtask

    initial begin
        #15 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 1'b0, 1'b0, 1'b0);

        // Normal trip: 4 incr, 1 decr, then close
        step(C_IDLE, 1'b1, 1'b0);
        chk_all("start", 0, 20, 1'b1, 1'b0, 1'b0);
        repeat (4) step(C_INC, 1'b0, 1'b0);
        chk_all("inc4", 4, 40, 1'b1, 1'b0, 1'b0);
        step(C_DEC, 1'b0, 1'b0);
        chk_all("dec1", 3, 35, 1'b1, 1'b0, 1'b0);
        step(C_IDLE, 1'b0, 1'b1);
        chk_all("end", 3, 35, 1'b0, 1'b1, 1'b0);
        step(C_INC, 1'b0, 1'b0);
        chk_all("after_done", 3, 35, 1'b0, 1'b0, 1'b0);

        // Async reset mid-trip
        step(C_IDLE, 1'b1, 1'b0);
        step(C_INC, 1'b0, 1'b0);
        chk_all("pre_rst", 1, 25, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_all("mid_rst", 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Floor at zero distance, then saturate distance at max
        step(C_IDLE, 1'b1, 1'b0);
        repeat (2) step(C_DEC, 1'b0, 1'b0);
        chk_all("floor", 0, 20, 1'b1, 1'b0, 1'b0);
        repeat (300) step(C_INC, 1'b0, 1'b0);
        chk_all("dist_max", 255, 1295, 1'b1, 1'b0, 1'b0);
        repeat (2) step(C_INC, 1'b0, 1'b0);
        chk_all("dist_hold", 255, 1295, 1'b1, 1'b0, 1'b0);
        step(C_DEC, 1'b0, 1'b0);
        chk_all("dec_top", 254, 1290, 1'b1, 1'b0, 1'b0);
        step(C_IDLE, 1'b0, 1'b1);
        step(C_IDLE, 1'b0, 1'b0);

        // Error counter clears on a good code; third consecutive error faults
        step(C_IDLE, 1'b1, 1'b0);
        step(C_ERR, 1'b0, 1'b0);
        step(C_ERR, 1'b0, 1'b0);
        step(C_INC, 1'b0, 1'b0);
        step(C_ERR, 1'b0, 1'b0);
        step(C_ERR, 1'b0, 1'b0);
        chk_all("err_reset", 1, 25, 1'b1, 1'b0, 1'b0);
        step(C_ERR, 1'b0, 1'b0);
        chk_all("fault", 1, 25, 1'b0, 1'b0, 1'b1);
        step(C_INC, 1'b0, 1'b1);
        chk_all("fault_frozen", 1, 25, 1'b0, 1'b0, 1'b1);
        step(C_IDLE, 1'b1, 1'b0);
        chk_all("fault_exit", 0, 20, 1'b1, 1'b0, 1'b0);

        // Code 110 is an error
        step(3'b110, 1'b0, 1'b0);
        step(3'b110, 1'b0, 1'b0);
        chk("c110_two.fault", 32'(fault), 32'd0);
        step(3'b110, 1'b0, 1'b0);
        chk_all("c110_fault", 0, 20, 1'b0, 1'b0, 1'b1);
        step(C_IDLE, 1'b0, 1'b0);

        // Start and end together in IDLE starts a trip
        step(C_INC, 1'b0, 1'b0);
        step(C_IDLE, 1'b1, 1'b0);
        step(C_IDLE, 1'b0, 1'b1);
        step(C_IDLE, 1'b0, 1'b0);
        step(C_IDLE, 1'b1, 1'b1);
        chk_all("start_end_idle", 0, 20, 1'b1, 1'b0, 1'b0);
        step(C_INC, 1'b0, 1'b1);
        chk_all("end_with_inc", 1, 25, 1'b0, 1'b1, 1'b0);
        // trip_start in DONE is ignored
        step(C_IDLE, 1'b1, 1'b0);
        chk_all("done_start", 1, 25, 1'b0, 1'b0, 1'b0);

        // Fault wins over a simultaneous trip_end
        step(C_IDLE, 1'b1, 1'b0);
        step(C_ERR, 1'b0, 1'b0);
        step(3'b111, 1'b0, 1'b0);
        step(3'b011, 1'b0, 1'b1);
        chk_all("fault_over_done", 0, 20, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
